// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder states, default line timing and GRB field layout.
// The transmit side imports the same constants so both ends agree on the wire format.
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } rx_state_e;

  // Default timing at 50 MHz, in clock cycles
  localparam int DEF_HI_THRESH = 30;
  localparam int DEF_MIN_HIGH  = 5;
  localparam int DEF_MAX_HIGH  = 75;
  localparam int DEF_LATCH_LOW = 2500;

  localparam int PIXEL_BITS = 24;
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous line input, with rise/fall detection
// on the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: measures high pulses into bits, packs 24-bit GRB pixels
// with their frame index, and detects the low-time latch that closes a frame.
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter int HI_THRESH = DEF_HI_THRESH,
  parameter int MIN_HIGH  = DEF_MIN_HIGH,
  parameter int MAX_HIGH  = DEF_MAX_HIGH,
  parameter int LATCH_LOW = DEF_LATCH_LOW,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_pixel_count,
  output logic             bit_error
);

  localparam int HC_W = $clog2(MAX_HIGH + 2);
  localparam int LC_W = $clog2(LATCH_LOW + 1);
  localparam logic [HC_W-1:0] HC_MIN   = HC_W'(MIN_HIGH);
  localparam logic [HC_W-1:0] HC_THR   = HC_W'(HI_THRESH);
  localparam logic [HC_W-1:0] HC_MAX   = HC_W'(MAX_HIGH);
  localparam logic [HC_W-1:0] HC_SAT   = HC_W'(MAX_HIGH + 1);
  localparam logic [LC_W-1:0] LC_LATCH = LC_W'(LATCH_LOW);
  localparam logic [4:0]      BIT_LAST = 5'(PIXEL_BITS);

  logic din_s, din_rise, din_fall;

  rx_state_e        state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [LC_W-1:0]  lc_q, lc_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [23:0]      pixel_data_q, pixel_data_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
  logic             frame_done_q, frame_done_d;
  logic [IDX_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             bit_error_q, bit_error_d;

  sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (din),
    .level_o(din_s),
    .rise_o (din_rise),
    .fall_o (din_fall)
  );

  always_comb begin
    state_d       = state_q;
    hc_d          = hc_q;
    lc_d          = lc_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    bit_error_d   = bit_error_q;

    // A full pixel is flushed one cycle after its last bit; a latch can never land here
    if (bit_cnt_q == BIT_LAST) begin
      pixel_valid_d = 1'b1;
      pixel_data_d  = shift_q;
      pixel_index_d = pix_cnt_q;
      bit_cnt_d     = '0;
      if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
    end

    case (state_q)
      S_SYNC: begin
        if (din_s) begin
          lc_d = '0;
        end else if (lc_q < LC_LATCH) begin
          lc_d = lc_q + 1'b1;
          if (lc_d == LC_LATCH) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (din_rise) begin
          state_d = S_HIGH;
          hc_d    = HC_W'(1);
        end
      end
      S_HIGH: begin
        // Malformed pulses abandon the whole frame and force a fresh resync
        if ((din_fall && hc_q < HC_MIN) || (!din_fall && hc_q >= HC_MAX)) begin
          bit_error_d = 1'b1;
          bit_cnt_d   = '0;
          shift_d     = '0;
          pix_cnt_d   = '0;
          lc_d        = '0;
          hc_d        = din_fall ? hc_q : HC_SAT;
          state_d     = S_SYNC;
        end else if (din_fall) begin
          shift_d   = {shift_q[22:0], (hc_q >= HC_THR)};
          bit_cnt_d = bit_cnt_q + 1'b1;
          lc_d      = LC_W'(1);
          state_d   = S_LOW;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      S_LOW: begin
        if (din_rise) begin
          state_d = S_HIGH;
          hc_d    = HC_W'(1);
        end else if (lc_q < LC_LATCH) begin
          lc_d = lc_q + 1'b1;
          if (lc_d == LC_LATCH) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = pix_cnt_q;
            if (bit_cnt_q != '0) bit_error_d = 1'b1;
            bit_cnt_d    = '0;
            shift_d      = '0;
            pix_cnt_d    = '0;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      hc_q          <= '0;
      lc_q          <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      bit_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      lc_q          <= lc_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      bit_error_q   <= bit_error_d;
    end
  end

  assign pixel_data        = pixel_data_q;
  assign pixel_valid       = pixel_valid_q;
  assign pixel_index       = pixel_index_q;
  assign frame_done        = frame_done_q;
  assign frame_pixel_count = frame_cnt_q;
  assign bit_error         = bit_error_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: drives NRZ pulses, records output strobes
// at the falling clock edge and compares them against hand-computed values.
module tb_ws2812_rx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixel_count;
  logic        bit_error;

  int cycleCount = 0;
  int lastFall   = 0;
  int fallMark   = 0;
  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  logic [23:0] pixData[$];
  int          pixIdx[$];
  int          pixCycle[$];
  int          frameCnt[$];
  int          frameCycle[$];

  ws2812_rx_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .din              (din),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_index      (pixel_index),
    .frame_done       (frame_done),
    .frame_pixel_count(frame_pixel_count),
    .bit_error        (bit_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record every strobe with the index of the rising edge that produced it
  always @(negedge clk) begin
    if (pixel_valid) begin
      pixData.push_back(pixel_data);
      pixIdx.push_back(int'(pixel_index));
      pixCycle.push_back(cycleCount);
    end
    if (frame_done) begin
      frameCnt.push_back(int'(frame_pixel_count));
      frameCycle.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One high pulse of 'high' cycles followed by 'low' cycles; called and returns at #1 after an edge
  task automatic applyStimulus(input int high, input int low);
    din = 1'b1;
    repeat (high) @(posedge clk);
    #1;
    din = 1'b0;
    lastFall = cycleCount;
    repeat (low) @(posedge clk);
    #1;
  endtask

  task automatic sendPixel(input logic [23:0] px);
    for (int i = 23; i >= 0; i--) begin
      if (px[i]) applyStimulus(40, 22);
      else       applyStimulus(20, 42);
    end
  endtask

  task automatic idleLow(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clearEvents();
    pixData.delete();
    pixIdx.delete();
    pixCycle.delete();
    frameCnt.delete();
    frameCycle.delete();
  endtask

  initial begin
    logic [23:0] partial;
    reset = 1'b1;
    din   = 1'b0;

    // Reset held while the line toggles
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      din = ~din;
    end
    checkOutput("reset_data", 32'(pixel_data), 32'h0);
    checkOutput("reset_flags", {13'h0, pixel_valid, frame_done, bit_error, pixel_index, frame_pixel_count}, 32'h0);
    reset = 1'b0;
    din   = 1'b0;

    // Traffic before the first latch period is ignored
    $display("[TB] sync period");
    sendPixel(24'hFFFFFF);
    idleLow(2600);
    checkOutput("sync_no_pixel", 32'(pixData.size()), 32'd0);
    checkOutput("sync_no_frame", 32'(frameCnt.size()), 32'd0);
    checkOutput("sync_outputs", {7'h0, bit_error, pixel_data}, 32'h0);

    $display("[TB] single pixel");
    clearEvents();
    sendPixel(24'hFF00A5);
    fallMark = lastFall;
    idleLow(2600);
    checkOutput("p1_count", 32'(pixData.size()), 32'd1);
    checkOutput("p1_data", 32'(pixData[0]), 32'hFF00A5);
    checkOutput("p1_index", 32'(pixIdx[0]), 32'd0);
    checkOutput("p1_latency", 32'(pixCycle[0] - fallMark), 32'd4);
    checkOutput("p1_frames", 32'(frameCnt.size()), 32'd1);
    checkOutput("p1_frame_latency", 32'(frameCycle[0] - fallMark), 32'd2502);
    checkOutput("p1_frame_count", 32'(frameCnt[0]), 32'd1);
    checkOutput("p1_held", {7'h0, bit_error, pixel_data}, 32'h00FF00A5);
    checkOutput("p1_held_count", 32'(frame_pixel_count), 32'd1);

    $display("[TB] three pixel frame then restart");
    clearEvents();
    sendPixel(24'h123456);
    sendPixel(24'hABCDEF);
    sendPixel(24'h000001);
    idleLow(2600);
    sendPixel(24'h5A5A5A);
    idleLow(2600);
    checkOutput("f3_count", 32'(pixData.size()), 32'd4);
    checkOutput("f3_data0", 32'(pixData[0]), 32'h123456);
    checkOutput("f3_data1", 32'(pixData[1]), 32'hABCDEF);
    checkOutput("f3_data2", 32'(pixData[2]), 32'h000001);
    checkOutput("f3_index", {8'h0, 8'(pixIdx[0]), 8'(pixIdx[1]), 8'(pixIdx[2])}, 32'h00000102);
    checkOutput("f3_frame_count", 32'(frameCnt[0]), 32'd3);
    checkOutput("f2_data", 32'(pixData[3]), 32'h5A5A5A);
    checkOutput("f2_index", 32'(pixIdx[3]), 32'd0);
    checkOutput("f2_frame_count", 32'(frameCnt[1]), 32'd1);

    $display("[TB] width boundaries");
    clearEvents();
    applyStimulus(5, 57);
    for (int i = 0; i < 22; i++) applyStimulus(40, 22);
    applyStimulus(29, 33);
    applyStimulus(75, 20);
    for (int i = 0; i < 22; i++) applyStimulus(20, 42);
    applyStimulus(30, 32);
    idleLow(2600);
    checkOutput("w_count", 32'(pixData.size()), 32'd2);
    checkOutput("w_5_29", 32'(pixData[0]), 32'h7FFFFE);
    checkOutput("w_75_30", 32'(pixData[1]), 32'h800001);
    checkOutput("w_frame_count", 32'(frameCnt[0]), 32'd2);
    checkOutput("w_no_error", 32'(bit_error), 32'd0);

    clearEvents();
    applyStimulus(4, 20);
    idleLow(2600);
    checkOutput("glitch_error", 32'(bit_error), 32'd1);
    checkOutput("glitch_no_pixel", 32'(pixData.size()), 32'd0);
    checkOutput("glitch_no_frame", 32'(frameCnt.size()), 32'd0);

    pulseReset();
    idleLow(2600);
    checkOutput("stuck_pre_error", 32'(bit_error), 32'd0);
    applyStimulus(76, 4);
    checkOutput("stuck_error", 32'(bit_error), 32'd1);

    $display("[TB] truncated frame");
    pulseReset();
    idleLow(2600);
    clearEvents();
    for (int i = 0; i < 12; i++) applyStimulus(40, 22);
    idleLow(2600);
    checkOutput("trunc_no_pixel", 32'(pixData.size()), 32'd0);
    checkOutput("trunc_frames", 32'(frameCnt.size()), 32'd1);
    checkOutput("trunc_frame_count", 32'(frameCnt[0]), 32'd0);
    checkOutput("trunc_error", 32'(bit_error), 32'd1);
    sendPixel(24'h0F0F0F);
    idleLow(2600);
    checkOutput("trunc_next_data", 32'(pixData[0]), 32'h0F0F0F);
    checkOutput("trunc_next_count", 32'(frameCnt[1]), 32'd1);
    checkOutput("trunc_error_held", 32'(bit_error), 32'd1);

    $display("[TB] reset mid-pixel");
    clearEvents();
    partial = 24'hC3C3C3;
    for (int i = 23; i >= 14; i--) begin
      if (partial[i]) applyStimulus(40, 22);
      else            applyStimulus(20, 42);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_reset_data", 32'(pixel_data), 32'h0);
    checkOutput("mid_reset_flags", {13'h0, pixel_valid, frame_done, bit_error, pixel_index, frame_pixel_count}, 32'h0);
    reset = 1'b0;
    sendPixel(24'h111111);
    idleLow(2600);
    sendPixel(24'h2468AC);
    idleLow(2600);
    checkOutput("mid_count", 32'(pixData.size()), 32'd1);
    checkOutput("mid_data", 32'(pixData[0]), 32'h2468AC);
    checkOutput("mid_index", 32'(pixIdx[0]), 32'd0);
    checkOutput("mid_frame_count", 32'(frameCnt[0]), 32'd1);
    checkOutput("mid_no_error", 32'(bit_error), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
